debug_trace_packetizer: RTL and testbench

DEBUG_TRACE_PACKETIZER -- requirements
Module: debug_trace_packetizer

---
 rtl/dii_package.sv | 16 +
 rtl/debug_trace_packetizer_if.sv | 21 ++
 rtl/debug_trace_fifo.sv | 41 ++++
 rtl/debug_trace_packetizer.sv | 109 ++++++++++
 tb/tb_debug_trace_packetizer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/dii_package.sv
// Shared debug-interconnect types: the flit format and reserved trace ids.
package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef struct packed {
    logic [15:0] id;
    logic [31:0] value;
  } trace_evt_t;

  localparam logic [15:0] TRACE_ID_END      = 16'h0002;
  localparam logic [15:0] TRACE_ID_OVERFLOW = 16'h0005;
endpackage

// File: rtl/debug_trace_packetizer_if.sv
// Trace-event input and debug NoC output of the packetizer.
// slave = packetizer side, master = event producer / NoC sink side.
interface debug_trace_packetizer_if;
  logic                 trace_valid;
  logic [15:0]          trace_id;
  logic [31:0]          trace_value;
  logic                 trace_ready;
  dii_package::dii_flit dbgnoc_out_flit;
  logic [1:0]           dbgnoc_out_valid;
  logic [1:0]           dbgnoc_out_ready;
  logic [15:0]          drop_count;

  modport slave (
    input  trace_valid, trace_id, trace_value, dbgnoc_out_ready,
    output trace_ready, dbgnoc_out_flit, dbgnoc_out_valid, drop_count
  );
  modport master (
    output trace_valid, trace_id, trace_value, dbgnoc_out_ready,
    input  trace_ready, dbgnoc_out_flit, dbgnoc_out_valid, drop_count
  );
endinterface

// File: rtl/debug_trace_fifo.sv
// Event FIFO; extra pointer MSB distinguishes full from empty.
module debug_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/debug_trace_packetizer.sv
// Packs trace events into 5-flit debug NoC packets; reports lost events
// with an overflow packet once the FIFO has drained.
module debug_trace_packetizer
  import dii_package::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DEST       = 16'h3000,
  parameter logic [15:0] SRC_ID     = 16'h0001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  debug_trace_packetizer_if.slave  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HDR_DEST = 3'd1;
  localparam logic [2:0] HDR_SRC  = 3'd2;
  localparam logic [2:0] DATA_LO  = 3'd3;
  localparam logic [2:0] DATA_HI  = 3'd4;
  localparam logic [2:0] ID_LAST  = 3'd5;

  logic [2:0]  state, state_nxt;
  logic        rdy_q, ovf_q;
  logic [15:0] drop_q, ovf_cnt_q;
  trace_evt_t  head, evt_in;
  logic        full, empty;
  logic        accept, out_hs, last_hs, pop, push, drop, ovf_done, start;
  dii_flit     flit;
  logic        unused_ready0;

  assign unused_ready0 = bus.dbgnoc_out_ready[0];

  assign evt_in   = '{id: bus.trace_id, value: bus.trace_value};
  assign accept   = bus.trace_valid && rdy_q;
  assign out_hs   = (state != IDLE) && bus.dbgnoc_out_ready[1];
  assign last_hs  = out_hs && (state == ID_LAST);
  assign pop      = last_hs && !ovf_q;
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;
  assign ovf_done = last_hs && ovf_q;
  // Bypassing the push lets a fresh event start its header one cycle after accept.
  assign start    = (state == IDLE) && (!empty || push || (drop_q != 16'h0));

  debug_trace_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(48)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (evt_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)  state_nxt = HDR_DEST;
      HDR_DEST: if (out_hs) state_nxt = HDR_SRC;
      HDR_SRC:  if (out_hs) state_nxt = DATA_LO;
      DATA_LO:  if (out_hs) state_nxt = DATA_HI;
      DATA_HI:  if (out_hs) state_nxt = ID_LAST;
      ID_LAST:  if (out_hs) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
      drop_q    <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= 1'b1;
      // Packet type and overflow count are frozen at start so stalled flits stay stable.
      if (start) begin
        ovf_q     <= empty && !push;
        ovf_cnt_q <= drop_q;
      end
      if (ovf_done)
        drop_q <= drop ? 16'h0001 : 16'h0000;
      else if (drop && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 16'h0001;
    end
  end

  always_comb begin
    flit = '0;
    case (state)
      HDR_DEST: flit.data = DEST;
      HDR_SRC:  flit.data = SRC_ID;
      DATA_LO:  flit.data = ovf_q ? ovf_cnt_q : head.value[15:0];
      DATA_HI:  flit.data = ovf_q ? 16'h0000  : head.value[31:16];
      ID_LAST: begin
        flit.data = ovf_q ? TRACE_ID_OVERFLOW : head.id;
        flit.last = 1'b1;
      end
      default: ;
    endcase
    flit.valid = (state != IDLE);
  end

  assign bus.dbgnoc_out_flit  = flit;
  assign bus.dbgnoc_out_valid = {state != IDLE, 1'b0};
  assign bus.trace_ready      = rdy_q;
  assign bus.drop_count       = drop_q;
endmodule

// File: tb/tb_debug_trace_packetizer.sv
// Directed bench for debug_trace_packetizer (FIFO_DEPTH=4, default DEST/SRC_ID).
module tb_debug_trace_packetizer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  debug_trace_packetizer_if bus();

  debug_trace_packetizer #(.FIFO_DEPTH(4), .DEST(16'h3000), .SRC_ID(16'h0001)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic flit_chk(input string tag, input logic [15:0] data, input logic last);
    chk({tag, "_valid"}, 32'(bus.dbgnoc_out_valid), 32'h2);
    chk({tag, "_flit"},  32'(bus.dbgnoc_out_flit), {14'b0, 1'b1, last, data});
  endtask

  task automatic push_evt(input logic [15:0] id, input logic [31:0] value);
    bus.trace_valid = 1'b1;
    bus.trace_id    = id;
    bus.trace_value = value;
    tick();
    bus.trace_valid = 1'b0;
  endtask

  task automatic expect_packet(input string tag, input logic [15:0] d2, input logic [15:0] d3,
                               input logic [15:0] d4);
    logic [15:0] exp_d [5];
    int n;
    exp_d = '{16'h3000, 16'h0001, d2, d3, d4};
    bus.dbgnoc_out_ready = 2'b10;
    n = 0;
    while (!bus.dbgnoc_out_valid[1] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, 32'(bus.dbgnoc_out_valid), 32'h2);
    for (int k = 0; k < 5; k++) begin
      flit_chk(tag, exp_d[k], k == 4);
      tick();
    end
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.trace_valid      = 1'b0;
    bus.trace_id         = '0;
    bus.trace_value      = '0;
    bus.dbgnoc_out_ready = 2'b00;

    // reset state
    #12;
    chk("rst_valid", 32'(bus.dbgnoc_out_valid), 32'h0);
    chk("rst_flit",  32'(bus.dbgnoc_out_flit), 32'h0);
    chk("rst_ready", 32'(bus.trace_ready), 32'h0);
    chk("rst_drop",  32'(bus.drop_count), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(bus.trace_ready), 32'h1);

    // single event, sink always ready
    bus.dbgnoc_out_ready = 2'b10;
    push_evt(16'h0010, 32'hDEADBEEF);
    flit_chk("s_f0", 16'h3000, 1'b0); tick();
    flit_chk("s_f1", 16'h0001, 1'b0); tick();
    flit_chk("s_f2", 16'hBEEF, 1'b0); tick();
    flit_chk("s_f3", 16'hDEAD, 1'b0); tick();
    flit_chk("s_f4", 16'h0010, 1'b1); tick();
    chk("s_idle", 32'(bus.dbgnoc_out_valid), 32'h0);

    // backpressure: ready[1] toggles every cycle
    bus.dbgnoc_out_ready = 2'b00;
    push_evt(16'h0010, 32'hDEADBEEF);
    begin
      logic [15:0] bp [5];
      bp = '{16'h3000, 16'h0001, 16'hBEEF, 16'hDEAD, 16'h0010};
      for (int k = 0; k < 5; k++) begin
        flit_chk("bp", bp[k], k == 4);
        tick();
        flit_chk("bp_hold", bp[k], k == 4);
        bus.dbgnoc_out_ready = 2'b10;
        tick();
        bus.dbgnoc_out_ready = 2'b00;
      end
    end
    chk("bp_idle", 32'(bus.dbgnoc_out_valid), 32'h0);

    // overflow: 7 events into a 4-deep FIFO while the sink stalls
    for (int i = 0; i < 7; i++)
      push_evt(16'h0020 + 16'(i), {16'hA000 + 16'(i), 16'hB000 + 16'(i)});
    chk("ovf_drop3", 32'(bus.drop_count), 32'd3);
    chk("ovf_ready_full", 32'(bus.trace_ready), 32'h1);
    expect_packet("ovf_e0", 16'hB000, 16'hA000, 16'h0020);
    chk("ovf_drop_mid", 32'(bus.drop_count), 32'd3);
    expect_packet("ovf_e1", 16'hB001, 16'hA001, 16'h0021);
    expect_packet("ovf_e2", 16'hB002, 16'hA002, 16'h0022);
    expect_packet("ovf_e3", 16'hB003, 16'hA003, 16'h0023);
    expect_packet("ovf_pkt", 16'h0003, 16'h0000, 16'h0005);
    chk("ovf_drop_clr", 32'(bus.drop_count), 32'd0);
    chk("ovf_idle", 32'(bus.dbgnoc_out_valid), 32'h0);

    // full FIFO, push lands on the pop cycle
    bus.dbgnoc_out_ready = 2'b00;
    for (int i = 0; i < 4; i++)
      push_evt(16'h0040 + 16'(i), {16'hC000 + 16'(i), 16'hD000 + 16'(i)});
    chk("full_drop0", 32'(bus.drop_count), 32'd0);
    bus.dbgnoc_out_ready = 2'b10;
    for (int k = 0; k < 4; k++) tick();
    flit_chk("full_last", 16'h0040, 1'b1);
    push_evt(16'h0055, 32'h11112222);
    chk("full_pushpop_drop", 32'(bus.drop_count), 32'd0);
    expect_packet("full_e1", 16'hD001, 16'hC001, 16'h0041);
    expect_packet("full_e2", 16'hD002, 16'hC002, 16'h0042);
    expect_packet("full_e3", 16'hD003, 16'hC003, 16'h0043);
    expect_packet("full_new", 16'h2222, 16'h1111, 16'h0055);
    chk("full_idle", 32'(bus.dbgnoc_out_valid), 32'h0);

    // reset while DATA_LO is on the bus
    bus.dbgnoc_out_ready = 2'b10;
    push_evt(16'h0066, 32'h12345678);
    tick();
    tick();
    flit_chk("mr_datalo", 16'h5678, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.dbgnoc_out_valid), 32'h0);
    chk("mr_flit",  32'(bus.dbgnoc_out_flit), 32'h0);
    chk("mr_ready", 32'(bus.trace_ready), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("mr_post_valid", 32'(bus.dbgnoc_out_valid), 32'h0);
    chk("mr_post_ready", 32'(bus.trace_ready), 32'h1);
    push_evt(16'h0077, 32'hCAFEF00D);
    expect_packet("mr_new", 16'hF00D, 16'hCAFE, 16'h0077);

    // end-of-trace marker passes through
    push_evt(16'h0002, 32'h00000000);
    expect_packet("end_mark", 16'h0000, 16'h0000, 16'h0002);
    chk("end_idle", 32'(bus.dbgnoc_out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
